// File: rtl/mem_stage_pkg.sv
// Shared types and width constants for the memory stage.
package mem_stage_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 4;

    // IDLE also covers the first cycle of every access.
    // WAIT holds the request until MemAck arrives.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic              mem_to_reg;
        logic              pc_src;
        logic [REG_AW-1:0] wa3;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] write_data;
    } ex_mem_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic              pc_src;
        logic [REG_AW-1:0] wa3;
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu_out;
    } mem_wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and memory.
interface mem_stage_if
    import mem_stage_pkg::*;
();

    logic              MemReq;
    logic              MemWe;
    logic [DATA_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemAck;
    logic [DATA_W-1:0] MemRData;

    modport master (
        output MemReq,
        output MemWe,
        output MemAddr,
        output MemWData,
        input  MemAck,
        input  MemRData
    );

    modport slave (
        input  MemReq,
        input  MemWe,
        input  MemAddr,
        input  MemWData,
        output MemAck,
        output MemRData
    );

endinterface

// File: rtl/mem_access_fsm.sv
// Request/acknowledge access FSM for the memory stage.
// Optional watchdog (abort + sticky error) enabled by macro MEM_TIMEOUT_EN.
module mem_access_fsm
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic memop,
    input  logic mem_ack,
    output logic mem_req,
`ifdef MEM_TIMEOUT_EN
    output logic abort,
    output logic mem_err,
`endif
    output logic mem_stall
);

    mem_state_t state_q, state_d;

`ifdef MEM_TIMEOUT_EN
    // Last WAIT cycle that still stalls is TIMEOUT_CYCLES-1; together with the
    // initial IDLE cycle that gives TIMEOUT_CYCLES stall cycles before abort.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic       err_q;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and request generation.
    always_comb begin
        state_d = state_q;
        mem_req = 1'b0;
`ifdef MEM_TIMEOUT_EN
        abort   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                mem_req = memop;
                if (memop && !mem_ack) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_d = IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    // Dropping the request here also releases the stall.
                    mem_req = 1'b0;
                    abort   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_stall = mem_req & ~mem_ack;

`ifdef MEM_TIMEOUT_EN
    // Wait counter: held at zero outside WAIT, so it starts from zero on entry.
    always_ff @(posedge clk) begin
        if (rst || state_q == IDLE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (abort) begin
            err_q <= 1'b1;
        end
    end

    assign mem_err = err_q;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM register, data-memory access and MEM/WB register.
// Optional access watchdog and MemErrM port enabled by macro MEM_TIMEOUT_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RegWriteE,
    input  logic              MemWriteE,
    input  logic              MemtoRegE,
    input  logic              PCSrcE,
    input  logic [REG_AW-1:0] WA3E,
    input  logic [DATA_W-1:0] ALUResultE,
    input  logic [DATA_W-1:0] WriteDataE,
    mem_stage_if.master       mem,
    output logic              MemStallM,
    output logic [DATA_W-1:0] ALUResultM,
    output logic              RegWriteM,
    output logic [REG_AW-1:0] WA3M,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic              PCSrcW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
`ifdef MEM_TIMEOUT_EN
    output logic              MemErrM,
`endif
    output logic [REG_AW-1:0] WA3W
);

    ex_mem_t exm_q;
    mem_wb_t mwb_q;
    logic    memop;
    logic    abort;

    assign memop = exm_q.mem_write | exm_q.mem_to_reg;

    mem_access_fsm #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
        .clk      (CLK),
        .rst      (RESET),
        .memop    (memop),
        .mem_ack  (mem.MemAck),
        .mem_req  (mem.MemReq),
`ifdef MEM_TIMEOUT_EN
        .abort    (abort),
        .mem_err  (MemErrM),
`endif
        .mem_stall(MemStallM)
    );

`ifndef MEM_TIMEOUT_EN
    assign abort = 1'b0;
`endif

    // EX/MEM register: frozen while an access stalls the pipeline.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            exm_q <= '0;
        end else if (!MemStallM) begin
            // A store never writes the register file, so drop its RegWrite here.
            exm_q.reg_write  <= RegWriteE & ~MemWriteE;
            exm_q.mem_write  <= MemWriteE;
            exm_q.mem_to_reg <= MemtoRegE;
            exm_q.pc_src     <= PCSrcE;
            exm_q.wa3        <= WA3E;
            exm_q.alu_result <= ALUResultE;
            exm_q.write_data <= WriteDataE;
        end
    end

    // MEM/WB register: bubble (control cleared, data held) on stall or abort.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mwb_q <= '0;
        end else if (MemStallM || abort) begin
            mwb_q.reg_write  <= 1'b0;
            mwb_q.mem_to_reg <= 1'b0;
            mwb_q.pc_src     <= 1'b0;
        end else begin
            mwb_q.reg_write  <= exm_q.reg_write;
            mwb_q.mem_to_reg <= exm_q.mem_to_reg;
            mwb_q.pc_src     <= exm_q.pc_src;
            mwb_q.wa3        <= exm_q.wa3;
            mwb_q.read_data  <= mem.MemRData;
            mwb_q.alu_out    <= exm_q.alu_result;
        end
    end

    assign mem.MemWe    = exm_q.mem_write;
    assign mem.MemAddr  = exm_q.alu_result;
    assign mem.MemWData = exm_q.write_data;

    assign ALUResultM = exm_q.alu_result;
    assign RegWriteM  = exm_q.reg_write;
    assign WA3M       = exm_q.wa3;

    assign RegWriteW  = mwb_q.reg_write;
    assign MemtoRegW  = mwb_q.mem_to_reg;
    assign PCSrcW     = mwb_q.pc_src;
    assign WA3W       = mwb_q.wa3;
    assign ReadDataW  = mwb_q.read_data;
    assign ALUOutW    = mwb_q.alu_out;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline, directly downstream of the execute stage.
- Holds the EX/MEM pipeline register, which captures the ALU result, store data and the post-condition control bits that execute produces.
- Runs a request/acknowledge data-memory access FSM and stalls the pipeline while an access is outstanding.
- Drives the MEM/WB register feeding writeback, plus ALUResultM for execute-stage forwarding.

Parameters:
- DATA_W, 32, data/address width
- REG_AW, 4, register-file address width
- TIMEOUT_CYCLES, 16, watchdog limit in wait cycles (used only with the optional feature)

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- RegWriteE  in  1  post-condition register write from execute
- MemWriteE  in  1  post-condition store enable from execute
- MemtoRegE  in  1  instruction is a load
- PCSrcE  in  1  post-condition PC write from execute
- WA3E  in  REG_AW  destination register
- ALUResultE  in  DATA_W  ALU result / memory address
- WriteDataE  in  DATA_W  forwarded store data
- MemReq  out  1  data-memory request
- MemWe  out  1  request is a write
- MemAddr  out  DATA_W  word address (ALUResultM)
- MemWData  out  DATA_W  store data
- MemAck  in  1  memory completes the request this cycle
- MemRData  in  DATA_W  load data, valid when MemAck=1
- MemStallM  out  1  freeze fetch/decode/execute and the EX/MEM register
- ALUResultM  out  DATA_W  forwarding path to execute
- RegWriteM  out  1  hazard-unit forwarding qualifier
- WA3M  out  REG_AW  hazard-unit forwarding compare
- RegWriteW, MemtoRegW, PCSrcW  out  1 each  writeback control
- ReadDataW, ALUOutW  out  DATA_W  writeback data
- WA3W  out  REG_AW  writeback destination

Behaviour:
- Reset (synchronous, when RESET=1 at the edge):
  - All EX/MEM and MEM/WB registers clear to 0.
  - FSM enters IDLE.
  - MemReq=0, MemStallM=0; every output reads 0.
- EX/MEM register:
  - Loads all E-side inputs each edge when MemStallM=0.
  - Holds its value when MemStallM=1.
- Memory operation: memop = MemWriteM | MemtoRegM. MemWe = MemWriteM. MemAddr = ALUResultM. MemWData = WriteDataM.
- FSM states IDLE, WAIT:
  - IDLE: MemReq = memop.
    - MemAck=1 in the same cycle: zero-wait access, no stall, stay IDLE.
    - MemAck=0: go to WAIT.
  - WAIT: MemReq=1, with address, data and We stable.
    - MemAck=1: return to IDLE.
- MemStallM = MemReq & ~MemAck (combinational).
- Latency: non-memory op is 1 cycle E→M and 1 cycle M→W. An access with n wait cycles adds n stall cycles.
- MEM/WB register:
  - Loads when MemStallM=0: ReadDataW ← MemRData, ALUOutW ← ALUResultM, plus control and WA3.
  - When MemStallM=1, loads a bubble: RegWriteW=0, MemtoRegW=0, PCSrcW=0. Data fields hold.
- A store never writes the register file.
- Boundary cases:
  - Back-to-back memory ops each issue their own request; no request is skipped or merged.
  - A MemAck while MemReq=0 is ignored.
  - RESET asserted in WAIT aborts the access: MemReq drops the next cycle and no writeback occurs.
  - Stall and RESET together: RESET wins.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Enabled:
  - An 8-bit wait counter clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES without MemAck: abort the access, return to IDLE, release the stall, and force a writeback bubble for that instruction.
  - Set sticky output MemErrM (1 bit, added port), which only RESET clears.
- Disabled: no counter and no MemErrM port; WAIT persists indefinitely.

Decomposition:
- Shared package holds:
  - mem_state_t enum {IDLE, WAIT}
  - Width constants DATA_W and REG_AW
  - ex_mem_t and mem_wb_t packed structs (control bits, WA3, data fields)
- One sub-module, mem_access_fsm: owns the state, MemReq/MemStallM and the optional watchdog.
- Pipeline registers stay in mem_stage.

Test Plan:
- ALU op: RegWriteE=1, WA3E=5, ALUResultE=0x1234 → ALUResultM=0x1234 after 1 edge; RegWriteW=1, ALUOutW=0x1234, WA3W=5 after 2 edges; MemReq stays 0.
- Zero-wait load: MemtoRegE=1, ALUResultE=0x40, MemAck=1 in the first M cycle with MemRData=0xDEADBEEF → MemStallM never 1; ReadDataW=0xDEADBEEF and MemtoRegW=1 next edge.
- 3-wait store: MemWriteE=1, ALUResultE=0x80, WriteDataE=0x55 → MemReq=1, MemWe=1, MemAddr=0x80, MemWData=0x55 held 4 cycles; MemStallM=1 for 3 cycles; writeback bubbles (RegWriteW=0) in those cycles.
- Back-to-back load then load with 1 wait each → two distinct requests (addresses 0x10, 0x14); each ReadDataW value correct; inputs held during stall.
- RESET pulsed during WAIT → the next cycle MemReq=0, MemStallM=0, FSM in IDLE, all W outputs 0.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, MemAck held 0 → stall released after 16 wait cycles; MemErrM=1 and stays 1 until RESET; RegWriteW=0 for that load.
